// File: rtl/sigma_pkg.sv
// Shared definitions for the sigma core memory: cycle states, widths,
// default timing and the latched request record.
// Optional feature macro used by this slice: SIGMA_MEM_PARITY_EN.
package sigma_pkg;

    localparam int MEM_ADDR_W          = 17;
    localparam int WORD_W              = 32;
    localparam int NUM_BYTES           = WORD_W / 8;
    localparam int DEF_ADDR_DEPTH_LOG2 = 12;
    localparam int DEF_ACCESS_CYCLES   = 2;
    localparam int DEF_RESTORE_CYCLES  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    // Request captured at acceptance; held for the whole memory cycle.
    // Byte enables are stored descending: be[3] covers the most significant byte.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [NUM_BYTES-1:0]  be;
        logic [WORD_W-1:0]     wdata;
        logic                  pinv;
    } mem_req_t;

    // Odd parity bit for one byte: set so the 9-bit group has an odd count of ones.
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/sigma_mem_array.sv
// Word storage with synchronous byte-enabled write and combinational read.
// With SIGMA_MEM_PARITY_EN defined, one odd-parity bit per byte is kept
// alongside the data and checked against the word being read.
module sigma_mem_array
    import sigma_pkg::*;
#(
    parameter int ADDR_DEPTH_LOG2 = DEF_ADDR_DEPTH_LOG2
) (
    input  logic                       clock,
    input  logic                       wr_en,
    input  logic [NUM_BYTES-1:0]       be,
    input  logic [ADDR_DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]          wdata,
    input  logic                       par_inv,
    output logic [WORD_W-1:0]          rdata,
    output logic                       rpar_err
);

    localparam int DEPTH = 2 ** ADDR_DEPTH_LOG2;

    // No reset on the array: contents survive reset and are undefined at power-up.
    logic [WORD_W-1:0] mem [DEPTH];

    // Commit only the enabled bytes of the addressed word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

`ifdef SIGMA_MEM_PARITY_EN
    logic [NUM_BYTES-1:0] par [DEPTH];
    logic [NUM_BYTES-1:0] calc_par;

    // Parity bits follow the same byte enables; par_inv deliberately corrupts them.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) par[addr][i] <= odd_par(wdata[8*i +: 8]) ^ par_inv;
            end
        end
    end

    // Recompute parity of the word being read and flag any byte that disagrees.
    always_comb begin
        calc_par = '0;
        for (int i = 0; i < NUM_BYTES; i++) calc_par[i] = odd_par(rdata[8*i +: 8]);
    end

    assign rpar_err = |(calc_par ^ par[addr]);
`else
    logic unused_par_inv;
    assign unused_par_inv = par_inv;
    assign rpar_err       = 1'b0;
`endif

endmodule

// File: rtl/sigma_core_memory.sv
// Core memory controller: IDLE -> ACCESS -> RESTORE cycle sequencing,
// request latching, installed-range check and registered read return.
// Optional parity storage/check enabled by defining SIGMA_MEM_PARITY_EN.
module sigma_core_memory
    import sigma_pkg::*;
#(
    parameter int ADDR_DEPTH_LOG2 = DEF_ADDR_DEPTH_LOG2,
    parameter int ACCESS_CYCLES   = DEF_ACCESS_CYCLES,
    parameter int RESTORE_CYCLES  = DEF_RESTORE_CYCLES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [0:3]   byte_en,
    input  logic [15:31] memory_address,
    input  logic [0:31]  write_data,
    input  logic         parity_invert,
    output logic         busy,
    output logic         done,
    output logic [0:31]  memory_data_in,
    output logic         nonexistent,
    output logic         parity_error
);

    localparam int MAXC  = (ACCESS_CYCLES > RESTORE_CYCLES) ? ACCESS_CYCLES : RESTORE_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESTORE_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    mem_req_t         cur;
    logic             accept;
    logic             acc_end;
    logic             in_range;
    logic             wr_en;
    logic [WORD_W-1:0] rdata;
    logic             rpar_err;

    // Phase register and in-phase clock counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next phase; the last restore clock doubles as the acceptance window so
    // back-to-back requests run one cycle per ACCESS+RESTORE clocks.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        acc_end  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    accept   = 1'b1;
                    state_nx = ST_ACCESS;
                    cnt_nx   = '0;
                end
            end
            ST_ACCESS: begin
                if (cnt == ACC_LAST) begin
                    acc_end  = 1'b1;
                    state_nx = ST_RESTORE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_RESTORE: begin
                if (cnt == RST_LAST) begin
                    cnt_nx = '0;
                    if (req) begin
                        accept   = 1'b1;
                        state_nx = ST_ACCESS;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Capture the request at acceptance; later input changes are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur <= '0;
        end else if (accept) begin
            cur.addr  <= memory_address;
            cur.we    <= we;
            cur.be    <= byte_en;
            cur.wdata <= write_data;
            cur.pinv  <= parity_invert;
        end
    end

    // Full-width compare of the upper bits, so out-of-range addresses never alias.
    assign in_range = ((cur.addr >> ADDR_DEPTH_LOG2) == '0);
    assign wr_en    = acc_end && cur.we && in_range;
    assign busy     = (state != ST_IDLE);

    sigma_mem_array #(
        .ADDR_DEPTH_LOG2 (ADDR_DEPTH_LOG2)
    ) u_array (
        .clock    (clock),
        .wr_en    (wr_en),
        .be       (cur.be),
        .addr     (cur.addr[ADDR_DEPTH_LOG2-1:0]),
        .wdata    (cur.wdata),
        .par_inv  (cur.pinv),
        .rdata    (rdata),
        .rpar_err (rpar_err)
    );

    // End-of-access pulses and read return; writes leave memory_data_in alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done           <= 1'b0;
            nonexistent    <= 1'b0;
            parity_error   <= 1'b0;
            memory_data_in <= '0;
        end else begin
            done         <= acc_end;
            nonexistent  <= acc_end && !in_range;
            parity_error <= acc_end && !cur.we && in_range && rpar_err;
            if (acc_end && !cur.we) memory_data_in <= in_range ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_sigma_core_memory.sv
// Directed bench for sigma_core_memory at default depth/timing (4096 words, 2+2 clocks).
// Honours SIGMA_MEM_PARITY_EN for the parity expectations.
module tb_sigma_core_memory;

    logic         clock;
    logic         reset;
    logic         req;
    logic         we;
    logic [0:3]   byte_en;
    logic [15:31] memory_address;
    logic [0:31]  write_data;
    logic         parity_invert;
    logic         busy;
    logic         done;
    logic [0:31]  memory_data_in;
    logic         nonexistent;
    logic         parity_error;

    int n_cmp = 0;
    int n_bad = 0;

    sigma_core_memory dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .we             (we),
        .byte_en        (byte_en),
        .memory_address (memory_address),
        .write_data     (write_data),
        .parity_invert  (parity_invert),
        .busy           (busy),
        .done           (done),
        .memory_data_in (memory_data_in),
        .nonexistent    (nonexistent),
        .parity_error   (parity_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One complete memory cycle, checking busy/done timing each clock.
    // Inputs are scrambled after acceptance to prove the request is latched.
    task automatic op(input string tag, input logic w, input logic [3:0] be,
                      input logic [16:0] a, input logic [31:0] d, input logic pi,
                      output logic [31:0] rd, output logic nx, output logic pe);
        req = 1'b1; we = w; byte_en = be; memory_address = a; write_data = d; parity_invert = pi;
        @(posedge clock); #1;
        req = 1'b0; we = ~w; byte_en = 4'hF; memory_address = '0; write_data = 32'hFFFF_FFFF; parity_invert = 1'b0;
        chk({tag, ".busy1"}, 32'(busy), 32'd1);
        chk({tag, ".done1"}, 32'(done), 32'd0);
        @(posedge clock); #1;
        chk({tag, ".done2"}, 32'(done), 32'd0);
        @(posedge clock); #1;
        chk({tag, ".busy3"}, 32'(busy), 32'd1);
        chk({tag, ".done3"}, 32'(done), 32'd1);
        rd = memory_data_in; nx = nonexistent; pe = parity_error;
        @(posedge clock); #1;
        chk({tag, ".busy4"}, 32'(busy), 32'd1);
        chk({tag, ".done4"}, 32'(done), 32'd0);
        chk({tag, ".nx4"}, 32'(nonexistent), 32'd0);
        @(posedge clock); #1;
        chk({tag, ".busy5"}, 32'(busy), 32'd0);
        byte_en = 4'h0; we = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        nx, pe;
        int          n_done, n_busy;
        logic        exp_pe;

        reset = 1'b0; req = 1'b0; we = 1'b0; byte_en = '0;
        memory_address = '0; write_data = '0; parity_invert = 1'b0;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.mdi", memory_data_in, 32'd0);
        chk("rst.nx", 32'(nonexistent), 32'd0);
        chk("rst.pe", 32'(parity_error), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Full write then read back.
        op("w10", 1'b1, 4'b1111, 17'h00010, 32'h1234_5678, 1'b0, rd, nx, pe);
        chk("w10.nx", 32'(nx), 32'd0);
        chk("w10.mdi", rd, 32'd0);
        op("r10", 1'b0, 4'b0000, 17'h00010, 32'h0, 1'b0, rd, nx, pe);
        chk("r10.data", rd, 32'h1234_5678);
        chk("r10.nx", 32'(nx), 32'd0);
        chk("r10.pe", 32'(pe), 32'd0);

        // Single-byte write into bits 8:15; read data register must not move.
        op("wbe", 1'b1, 4'b0100, 17'h00010, 32'hAABB_CCDD, 1'b0, rd, nx, pe);
        chk("wbe.hold", memory_data_in, 32'h1234_5678);
        op("rbe", 1'b0, 4'b0000, 17'h00010, 32'h0, 1'b0, rd, nx, pe);
        chk("rbe.data", rd, 32'h12BB_5678);

        // byte_en=0 still runs a full cycle and changes nothing.
        op("wbe0", 1'b1, 4'b0000, 17'h00010, 32'h0000_0000, 1'b0, rd, nx, pe);
        op("rbe0", 1'b0, 4'b0000, 17'h00010, 32'h0, 1'b0, rd, nx, pe);
        chk("rbe0.data", rd, 32'h12BB_5678);

        // Range boundary and aliasing.
        op("w0", 1'b1, 4'b1111, 17'h00000, 32'h0000_0000, 1'b0, rd, nx, pe);
        op("w0fff", 1'b1, 4'b1111, 17'h00FFF, 32'hCAFE_F00D, 1'b0, rd, nx, pe);
        op("r0fff", 1'b0, 4'b0000, 17'h00FFF, 32'h0, 1'b0, rd, nx, pe);
        chk("r0fff.data", rd, 32'hCAFE_F00D);
        chk("r0fff.nx", 32'(nx), 32'd0);
        op("r1000", 1'b0, 4'b0000, 17'h01000, 32'h0, 1'b0, rd, nx, pe);
        chk("r1000.data", rd, 32'd0);
        chk("r1000.nx", 32'(nx), 32'd1);
        op("w1000", 1'b1, 4'b1111, 17'h01000, 32'hDEAD_BEEF, 1'b0, rd, nx, pe);
        chk("w1000.nx", 32'(nx), 32'd1);
        op("r0", 1'b0, 4'b0000, 17'h00000, 32'h0, 1'b0, rd, nx, pe);
        chk("r0.data", rd, 32'd0);
        chk("r0.nx", 32'(nx), 32'd0);
        op("r1ffff", 1'b0, 4'b0000, 17'h1FFFF, 32'h0, 1'b0, rd, nx, pe);
        chk("r1ffff.nx", 32'(nx), 32'd1);
        chk("r1ffff.data", rd, 32'd0);

        // req held high: one cycle every 4 clocks, busy never drops.
        req = 1'b1; we = 1'b0; memory_address = 17'h00010;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        req = 1'b0;
        chk("hold.dones", 32'(n_done), 32'd3);
        chk("hold.busy", 32'(n_busy), 32'd12);
        @(posedge clock); #1;
        chk("hold.idle", 32'(busy), 32'd0);

        // Reset one clock into a write's access phase: write must not land.
        req = 1'b1; we = 1'b1; byte_en = 4'b1111; memory_address = 17'h00010; write_data = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.mdi", memory_data_in, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        op("rabort", 1'b0, 4'b0000, 17'h00010, 32'h0, 1'b0, rd, nx, pe);
        chk("rabort.data", rd, 32'h12BB_5678);

        // Parity corruption test aid.
`ifdef SIGMA_MEM_PARITY_EN
        exp_pe = 1'b1;
`else
        exp_pe = 1'b0;
`endif
        op("wpar", 1'b1, 4'b1111, 17'h00020, 32'h0000_0055, 1'b1, rd, nx, pe);
        chk("wpar.pe", 32'(pe), 32'd0);
        op("rpar", 1'b0, 4'b0000, 17'h00020, 32'h0, 1'b0, rd, nx, pe);
        chk("rpar.data", rd, 32'h0000_0055);
        chk("rpar.pe", 32'(pe), 32'(exp_pe));
        op("wpar2", 1'b1, 4'b1111, 17'h00020, 32'h0000_0055, 1'b0, rd, nx, pe);
        op("rpar2", 1'b0, 4'b0000, 17'h00020, 32'h0, 1'b0, rd, nx, pe);
        chk("rpar2.pe", 32'(pe), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sigma_core_memory.md
SIGMA_CORE_MEMORY -- requirements
Module: sigma_core_memory

Interface
REQ-001 SHALL have parameter ADDR_DEPTH_LOG2, default 12, giving installed words = 2**ADDR_DEPTH_LOG2 (range 1..17).
REQ-002 SHALL have parameter ACCESS_CYCLES, default 2, giving the read/write phase length in clocks (>=1).
REQ-003 SHALL have parameter RESTORE_CYCLES, default 2, giving the restore phase length in clocks (>=1).
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, 1, access request, sampled only while busy=0.
REQ-007 SHALL have port we, input, 1, where 1=write and 0=read, sampled with req.
REQ-008 SHALL have port byte_en, input, 4, write byte enables; bit 0 selects word bits 0:7 (big-endian numbering).
REQ-009 SHALL have port memory_address, input, 17 bits [15:31], the word address from the CPU.
REQ-010 SHALL have port write_data, input, 32 bits [0:31], the store data.
REQ-011 SHALL have port parity_invert, input, 1, which inverts the parity stored by the accepted write (test aid).
REQ-012 SHALL have port busy, output, 1, high while a memory cycle is in progress.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse at the end of the access phase.
REQ-014 SHALL have port memory_data_in, output, 32 bits [0:31], read data to the CPU.
REQ-015 SHALL have port nonexistent, output, 1, a pulse coincident with done when the address is not installed.
REQ-016 SHALL have port parity_error, output, 1, a pulse coincident with done on a read parity mismatch.

Function
REQ-017 SHALL implement states IDLE, ACCESS and RESTORE: IDLE->ACCESS on req; ACCESS->RESTORE after ACCESS_CYCLES clocks; RESTORE->IDLE after RESTORE_CYCLES clocks.
REQ-018 SHALL, on acceptance at edge N, latch memory_address, we, byte_en, write_data and parity_invert, then hold busy=1 from edge N through edge N+ACCESS_CYCLES+RESTORE_CYCLES; the earliest next acceptance is at that final edge.
REQ-019 SHALL ignore req while busy=1, with no queuing.
REQ-020 SHALL assert done for exactly the one cycle following edge N+ACCESS_CYCLES, for both reads and writes.
REQ-021 SHALL, for a read, update memory_data_in at that same edge; memory_data_in then holds until the next read's done, and writes never change it.
REQ-022 SHALL, for a write, commit only the enabled bytes at edge N+ACCESS_CYCLES; byte_en=0 leaves the array unchanged but still runs a full cycle.
REQ-023 SHALL treat an address >= 2**ADDR_DEPTH_LOG2 as nonexistent: the write is suppressed, read data becomes 0, nonexistent pulses with done, and cycle timing is unchanged.
REQ-024 SHALL not alias addresses: upper address bits are compared, never truncated.

Reset
REQ-025 SHALL, on reset low, immediately force IDLE, busy=0, done=0, nonexistent=0, parity_error=0 and memory_data_in=0.
REQ-026 SHALL, on reset mid-cycle, abort the cycle; a write not yet committed (before edge N+ACCESS_CYCLES) SHALL not be committed.
REQ-027 SHALL not clear the array contents on reset; contents are undefined after power-up.

Configuration
REQ-028 SHALL, with SIGMA_MEM_PARITY_EN defined, store one odd-parity bit per byte, updating it only for the enabled bytes and inverting it when the latched parity_invert=1.
REQ-029 SHALL, with SIGMA_MEM_PARITY_EN defined, recompute parity on a read of an installed address; any byte mismatch pulses parity_error with done, and the data is still returned.
REQ-030 SHALL, without SIGMA_MEM_PARITY_EN, omit parity storage, tie parity_error to 0 and ignore parity_invert; the port list is identical in both builds.

Structure
REQ-031 SHALL take from shared package sigma_pkg: the state enum, MEM_ADDR_W=17, WORD_W=32 and the default timing constants.
REQ-032 SHALL instantiate one sub-module, sigma_mem_array, which provides synchronous byte-enabled storage plus the optional parity bits; sigma_core_memory keeps the FSM, counters and range check.

Verification
REQ-033 SHALL be verified by: write 0x12345678 to 0x00010 with byte_en=1111, then read 0x00010 -> done at +2 clocks, memory_data_in=0x12345678, busy high for 4 clocks.
REQ-034 SHALL be verified by: after REQ-033, write 0xAABBCCDD with byte_en=0100, then read -> 0x12BB5678.
REQ-035 SHALL be verified by: read 0x01000 (depth 4096) -> nonexistent and done pulse together, memory_data_in=0; a write to 0x01000 followed by a read of 0x00000 shows no alias change.
REQ-036 SHALL be verified by: req held high during busy -> exactly one cycle per 4 clocks; reset low 1 clock into the ACCESS phase of a write of 0xFFFFFFFF to 0x00010 -> busy=0 and a later read returns the old value.
REQ-037 SHALL be verified by: with SIGMA_MEM_PARITY_EN, write with parity_invert=1 then read -> parity_error=1 with done and data intact; without the macro parity_error stays 0.
